// File: rtl/line_draw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_draw_pkg
// Description : Screen geometry and plotter state encoding shared by the
//               line-drawer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package line_draw_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FB_PIXELS = SCREEN_W * SCREEN_H;
    localparam int FB_ADDR_W = 19;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } plot_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_clear_counter.sv
`default_nettype none
// ============================================================================
// Module      : fb_clear_counter
// Description : Framebuffer sweep counter with synchronous start, enable and
//               terminal-count flag at the last pixel address.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_clear_counter
    import line_draw_pkg::*;
#(
    parameter int LAST = FB_PIXELS - 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 enable,
    output logic [FB_ADDR_W-1:0] count,
    output logic                 terminal
);

    logic [FB_ADDR_W-1:0] r_count_q;
    logic [FB_ADDR_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (start) begin
            w_count_d = '0;
        end else if (enable) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count    = r_count_q;
    assign terminal = (r_count_q == FB_ADDR_W'(LAST));

endmodule
`default_nettype wire

// File: rtl/pixel_plotter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_plotter
// Description : Converts (x, y, color) pixels into linear framebuffer writes,
//               drops off-screen pixels and runs a full-screen clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_plotter
    import line_draw_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [9:0]           pix_x,
    input  logic [8:0]           pix_y,
    input  logic                 pix_color,
    input  logic                 clear_req,
    input  logic                 clear_color,
    output logic                 busy,
    output logic                 mem_we,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic                 mem_wdata,
    output logic [CNT_W-1:0]     dropped_count
);

    localparam int c_last_addr = WIDTH * HEIGHT - 1;

    plot_state_e          r_state_q, w_state_d;
    logic                 r_we_q,    w_we_d;
    logic [FB_ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic                 r_wdata_q, w_wdata_d;
    logic                 r_color_q, w_color_d;
    logic [CNT_W-1:0]     r_drop_q,  w_drop_d;

    logic                 w_accept;
    logic                 w_in_bounds;
    logic [FB_ADDR_W-1:0] w_pix_addr;
    logic                 w_cnt_start;
    logic                 w_cnt_en;
    logic                 w_cnt_last;
    logic [FB_ADDR_W-1:0] w_cnt;

    fb_clear_counter #(
        .LAST     (c_last_addr)
    ) u_clear_cnt (
        .clk      (clk),
        .reset    (reset),
        .start    (w_cnt_start),
        .enable   (w_cnt_en),
        .count    (w_cnt),
        .terminal (w_cnt_last)
    );

    assign pix_ready   = (r_state_q == S_IDLE) && !clear_req && !reset;
    assign w_accept    = pix_valid && pix_ready;
    assign w_in_bounds = ({1'b0, pix_x} < 11'(WIDTH)) && ({1'b0, pix_y} < 10'(HEIGHT));
    assign w_pix_addr  = FB_ADDR_W'(pix_y) * FB_ADDR_W'(WIDTH) + FB_ADDR_W'(pix_x);

    always_comb begin
        w_state_d   = r_state_q;
        w_we_d      = 1'b0;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_color_d   = r_color_q;
        w_drop_d    = r_drop_q;
        w_cnt_start = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_in_bounds) begin
                        w_we_d    = 1'b1;
                        w_addr_d  = w_pix_addr;
                        w_wdata_d = pix_color;
                    end else if (r_drop_q != {CNT_W{1'b1}}) begin
                        w_drop_d = r_drop_q + 1'b1;
                    end
                end
                // pix_ready is low whenever clear_req is high, so no pixel competes here
                if (clear_req) begin
                    w_color_d   = clear_color;
                    w_cnt_start = 1'b1;
                    w_state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_addr_d  = w_cnt;
                w_wdata_d = r_color_q;
                w_cnt_en  = 1'b1;
                if (w_cnt_last) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= S_IDLE;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= 1'b0;
            r_color_q <= 1'b0;
            r_drop_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_color_q <= w_color_d;
            r_drop_q  <= w_drop_d;
        end
    end

    // Clear writes come straight from the sweep counter; pixel writes from the registers
    assign busy          = (r_state_q == S_CLEAR);
    assign mem_we        = busy || r_we_q;
    assign mem_addr      = busy ? w_cnt     : r_addr_q;
    assign mem_wdata     = busy ? r_color_q : r_wdata_q;
    assign dropped_count = r_drop_q;

endmodule
`default_nettype wire
